// File: rtl/frame_row_scheduler_if.sv
// frame_row_scheduler_if
// Groups the request/grant, row-source, shifter and status signals of the
// frame row scheduler. The scheduler connects through the master modport.
// The environment connects through the slave modport: the row sources,
// the shifter and the requesters.
//
// Parameters:
//   ROW_BITS  width of one row (1 bit per pixel)
//   RIDX_W    width of the row index
//
// Signals (directions as seen by the scheduler):
//   iREQ[1:0]        in   frame request per source, held until oFRAME_DONE
//   oGNT[1:0]        out  one-hot grant, held for the whole frame
//   oROW_RD          out  row fetch request to the granted source
//   iROW_VALID[1:0]  in   per-source row-data-valid
//   iROW_DATA0/1     in   row data from source 0 / source 1
//   oSER_DATA        out  latched row presented to the shifter
//   oSER_START       out  one-cycle shifter start pulse
//   iSER_FINISHED    in   shifter row-complete pulse
//   oROW_IDX         out  index of the row in flight
//   oFRAME_DONE      out  one-cycle pulse after the last row
//   oBUSY            out  high whenever the scheduler is not idle
//   oERR             out  one-cycle watchdog abort pulse
interface frame_row_scheduler_if #(
    parameter int ROW_BITS = 640,
    parameter int RIDX_W   = 9
);
    logic [1:0]          iREQ;
    logic [1:0]          oGNT;
    logic                oROW_RD;
    logic [1:0]          iROW_VALID;
    logic [ROW_BITS-1:0] iROW_DATA0;
    logic [ROW_BITS-1:0] iROW_DATA1;
    logic [ROW_BITS-1:0] oSER_DATA;
    logic                oSER_START;
    logic                iSER_FINISHED;
    logic [RIDX_W-1:0]   oROW_IDX;
    logic                oFRAME_DONE;
    logic                oBUSY;
    logic                oERR;

    modport master (
        input  iREQ, iROW_VALID, iROW_DATA0, iROW_DATA1, iSER_FINISHED,
        output oGNT, oROW_RD, oSER_DATA, oSER_START, oROW_IDX,
               oFRAME_DONE, oBUSY, oERR
    );

    modport slave (
        output iREQ, iROW_VALID, iROW_DATA0, iROW_DATA1, iSER_FINISHED,
        input  oGNT, oROW_RD, oSER_DATA, oSER_START, oROW_IDX,
               oFRAME_DONE, oBUSY, oERR
    );
endinterface

// File: rtl/frame_row_scheduler.sv
// frame_row_scheduler
// Drives a row-wide parallel-to-serial shifter through whole frames, one row
// at a time. Two row sources compete for frame ownership: source 0 is the
// live capture path, source 1 is the stored flash image. Ownership is
// round-robin when both request. For each row it fetches from the granted
// source, latches the row, pulses the shifter start and waits for the
// shifter's finished pulse; a frame-done pulse follows the last row.
//
// Ports:
//   iCLK    clock, rising edge
//   iRST_n  asynchronous active-low reset
//   bus     frame_row_scheduler_if.master (requests, grant, row sources,
//           shifter handshake, row index, frame done, busy, error)
//
// Build option:
//   FRAME_ROW_SCHED_WATCHDOG_EN  when defined, a row that is not finished
//   within ROW_BITS+16 cycles of entering WAIT aborts the frame with a
//   one-cycle oERR pulse. When undefined, oERR is constant 0 and WAIT
//   waits indefinitely.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | no frame owned; arbitrate between requests
// FETCH | oROW_RD high, waiting for valid from the granted source
// START | row latched, one-cycle shifter start pulse
// WAIT  | shifter busy with the row, waiting for finished
// DONE  | one-cycle frame-done pulse, grant released on exit
module frame_row_scheduler #(
    parameter int ROW_BITS = 640,
    parameter int ROWS     = 480,
    parameter int RIDX_W   = (ROWS > 1) ? $clog2(ROWS) : 1
) (
    input  logic                 iCLK,
    input  logic                 iRST_n,
    frame_row_scheduler_if.master bus
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        START = 3'd2,
        WAIT  = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam logic [RIDX_W-1:0] LAST_ROW = RIDX_W'(ROWS - 1);

    state_t              state_q, state_d;
    logic [1:0]          gnt_q, gnt_d;
    logic                row_rd_q, row_rd_d;
    logic [ROW_BITS-1:0] ser_data_q, ser_data_d;
    logic                ser_start_q, ser_start_d;
    logic [RIDX_W-1:0]   row_idx_q, row_idx_d;
    logic                frame_done_q, frame_done_d;
    logic                busy_q, busy_d;
    // 1 favours source 1 when both sources request
    logic                ptr_q, ptr_d;
    logic                err_d;
    logic                win;
    logic                g_sel;

`ifdef FRAME_ROW_SCHED_WATCHDOG_EN
    localparam int WD_W = $clog2(ROW_BITS + 16);
    // Loaded on entry to WAIT; reaching zero without finished means the
    // row has been outstanding for ROW_BITS+16 cycles.
    localparam logic [WD_W-1:0] WD_LOAD = WD_W'(ROW_BITS + 15);
    logic [WD_W-1:0] wd_q, wd_d;
    logic            err_q;
`endif

    // Granted source index; gnt_q is one-hot whenever it is used.
    assign g_sel = gnt_q[1];

    always_comb begin
        state_d      = state_q;
        gnt_d        = gnt_q;
        row_rd_d     = 1'b0;
        ser_data_d   = ser_data_q;
        ser_start_d  = 1'b0;
        row_idx_d    = row_idx_q;
        frame_done_d = 1'b0;
        ptr_d        = ptr_q;
        err_d        = 1'b0;
        win          = 1'b0;
`ifdef FRAME_ROW_SCHED_WATCHDOG_EN
        wd_d         = wd_q;
`endif
        case (state_q)
            IDLE: begin
                if (|bus.iREQ) begin
                    // A lone requester wins outright; the pointer only
                    // breaks ties.
                    win       = (bus.iREQ == 2'b11) ? ptr_q : bus.iREQ[1];
                    gnt_d     = win ? 2'b10 : 2'b01;
                    row_idx_d = '0;
                    row_rd_d  = 1'b1;
                    state_d   = FETCH;
                end
            end
            FETCH: begin
                if (!bus.iREQ[g_sel]) begin
                    state_d = IDLE;
                    gnt_d   = 2'b00;
                    ptr_d   = ~ptr_q;
                end else if (bus.iROW_VALID[g_sel]) begin
                    ser_data_d  = g_sel ? bus.iROW_DATA1 : bus.iROW_DATA0;
                    ser_start_d = 1'b1;
                    state_d     = START;
                end else begin
                    row_rd_d = 1'b1;
                end
            end
            START: begin
                state_d = WAIT;
`ifdef FRAME_ROW_SCHED_WATCHDOG_EN
                wd_d    = WD_LOAD;
`endif
            end
            WAIT: begin
                if (bus.iSER_FINISHED) begin
                    if (row_idx_q == LAST_ROW) begin
                        frame_done_d = 1'b1;
                        state_d      = DONE;
                    end else begin
                        row_idx_d = row_idx_q + RIDX_W'(1);
                        row_rd_d  = 1'b1;
                        state_d   = FETCH;
                    end
                end
`ifdef FRAME_ROW_SCHED_WATCHDOG_EN
                else if (wd_q == '0) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                    gnt_d   = 2'b00;
                    ptr_d   = ~ptr_q;
                end else begin
                    wd_d = wd_q - WD_W'(1);
                end
`endif
            end
            DONE: begin
                state_d = IDLE;
                gnt_d   = 2'b00;
                ptr_d   = ~g_sel;
            end
            default: begin
                state_d = IDLE;
                gnt_d   = 2'b00;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            state_q      <= IDLE;
            gnt_q        <= 2'b00;
            row_rd_q     <= 1'b0;
            ser_data_q   <= '0;
            ser_start_q  <= 1'b0;
            row_idx_q    <= '0;
            frame_done_q <= 1'b0;
            busy_q       <= 1'b0;
            ptr_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            gnt_q        <= gnt_d;
            row_rd_q     <= row_rd_d;
            ser_data_q   <= ser_data_d;
            ser_start_q  <= ser_start_d;
            row_idx_q    <= row_idx_d;
            frame_done_q <= frame_done_d;
            busy_q       <= busy_d;
            ptr_q        <= ptr_d;
        end
    end

`ifdef FRAME_ROW_SCHED_WATCHDOG_EN
    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            wd_q  <= '0;
            err_q <= 1'b0;
        end else begin
            wd_q  <= wd_d;
            err_q <= err_d;
        end
    end

    assign bus.oERR = err_q;
`else
    // Without the watchdog nothing can raise an error.
    logic unused_err;
    assign unused_err = err_d;
    assign bus.oERR   = 1'b0;
`endif

    assign bus.oGNT        = gnt_q;
    assign bus.oROW_RD     = row_rd_q;
    assign bus.oSER_DATA   = ser_data_q;
    assign bus.oSER_START  = ser_start_q;
    assign bus.oROW_IDX    = row_idx_q;
    assign bus.oFRAME_DONE = frame_done_q;
    assign bus.oBUSY       = busy_q;

endmodule

// File: tb/tb_frame_row_scheduler.sv
// tb_frame_row_scheduler
// Directed bench for frame_row_scheduler with ROW_BITS=8, ROWS=4. Row sources
// answer one cycle after oROW_RD; the shifter answers 9 cycles after start.
// Honours FRAME_ROW_SCHED_WATCHDOG_EN to choose the expected watchdog result.
module tb_frame_row_scheduler;

    logic clk;
    logic rst_n;
    int   n_pass;
    int   n_total;
    logic [7:0] last_data;
    int   err_cyc;
    int   err_cnt;

    frame_row_scheduler_if #(.ROW_BITS(8), .RIDX_W(2)) bus ();

    frame_row_scheduler #(.ROW_BITS(8), .ROWS(4), .RIDX_W(2)) dut (
        .iCLK   (clk),
        .iRST_n (rst_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_gnt"},        32'(bus.oGNT),        0);
        check({tag, "_row_rd"},     32'(bus.oROW_RD),     0);
        check({tag, "_ser_start"},  32'(bus.oSER_START),  0);
        check({tag, "_frame_done"}, 32'(bus.oFRAME_DONE), 0);
        check({tag, "_busy"},       32'(bus.oBUSY),       0);
        check({tag, "_err"},        32'(bus.oERR),        0);
        check({tag, "_ser_data"},   32'(bus.oSER_DATA),   0);
        check({tag, "_row_idx"},    32'(bus.oROW_IDX),    0);
    endtask

    // Entered in a cycle with oROW_RD high; leaves in the START cycle.
    task automatic fetch_and_start(input int src, input logic [7:0] data, input bit stray);
        logic [1:0] exp_gnt;
        exp_gnt = (src == 1) ? 2'b10 : 2'b01;
        check("fetch_row_rd", 32'(bus.oROW_RD), 1);
        check("fetch_gnt", 32'(bus.oGNT), 32'(exp_gnt));
        if (stray) begin
            // valid from the source that does not own the frame
            bus.iROW_VALID = (src == 1) ? 2'b01 : 2'b10;
            bus.iROW_DATA0 = 8'h5A;
            bus.iROW_DATA1 = 8'h5A;
            tick;
            bus.iROW_VALID = 2'b00;
            check("stray_valid_row_rd", 32'(bus.oROW_RD), 1);
            check("stray_valid_no_start", 32'(bus.oSER_START), 0);
            check("stray_valid_no_latch", 32'(bus.oSER_DATA), 32'(last_data));
        end else begin
            tick;
        end
        if (src == 1) begin
            bus.iROW_DATA1 = data;
            bus.iROW_DATA0 = ~data;
            bus.iROW_VALID = 2'b10;
        end else begin
            bus.iROW_DATA0 = data;
            bus.iROW_DATA1 = ~data;
            bus.iROW_VALID = 2'b01;
        end
        tick;
        bus.iROW_VALID = 2'b00;
        check("start_pulse", 32'(bus.oSER_START), 1);
        check("ser_data", 32'(bus.oSER_DATA), 32'(data));
        check("start_row_rd_low", 32'(bus.oROW_RD), 0);
        last_data = data;
    endtask

    // One full row; leaves in the cycle after the finished pulse was sampled.
    task automatic do_row(input int src, input logic [7:0] data, input int idx,
                          input bit stray, input bit drop);
        check("row_idx", 32'(bus.oROW_IDX), 32'(idx));
        fetch_and_start(src, data, stray);
        if (stray) bus.iSER_FINISHED = 1'b1;
        tick;
        bus.iSER_FINISHED = 1'b0;
        check("wait_start_low", 32'(bus.oSER_START), 0);
        check("wait_row_rd_low", 32'(bus.oROW_RD), 0);
        check("wait_busy", 32'(bus.oBUSY), 1);
        check("wait_no_done", 32'(bus.oFRAME_DONE), 0);
        check("wait_no_err", 32'(bus.oERR), 0);
        if (drop) bus.iREQ = 2'b00;
        repeat (8) tick;
        bus.iSER_FINISHED = 1'b1;
        tick;
        bus.iSER_FINISHED = 1'b0;
        if (idx < 3) begin
            check("next_row_rd", 32'(bus.oROW_RD), 1);
            check("next_no_done", 32'(bus.oFRAME_DONE), 0);
        end
    endtask

    task automatic check_done(input logic [1:0] exp_gnt);
        check("done_pulse", 32'(bus.oFRAME_DONE), 1);
        check("done_gnt", 32'(bus.oGNT), 32'(exp_gnt));
        check("done_busy", 32'(bus.oBUSY), 1);
        check("done_row_rd", 32'(bus.oROW_RD), 0);
    endtask

    task automatic check_idle_after_done;
        check("idle_done_low", 32'(bus.oFRAME_DONE), 0);
        check("idle_busy", 32'(bus.oBUSY), 0);
        check("idle_gnt", 32'(bus.oGNT), 0);
    endtask

    initial begin
        n_pass            = 0;
        n_total           = 0;
        last_data         = 8'h00;
        err_cyc           = -1;
        err_cnt           = 0;
        rst_n             = 1'b0;
        bus.iREQ          = 2'b00;
        bus.iROW_VALID    = 2'b00;
        bus.iROW_DATA0    = 8'h00;
        bus.iROW_DATA1    = 8'h00;
        bus.iSER_FINISHED = 1'b0;

        #2;
        check_all_zero("reset");
        #20;
        rst_n = 1'b1;
        tick;

        // Contention: both request across two frames; source 0 first.
        bus.iREQ = 2'b11;
        tick;
        check("cont1_gnt", 32'(bus.oGNT), 1);
        check("cont1_busy", 32'(bus.oBUSY), 1);
        do_row(0, 8'h11, 0, 1'b0, 1'b0);
        do_row(0, 8'h22, 1, 1'b0, 1'b0);
        do_row(0, 8'h33, 2, 1'b0, 1'b0);
        do_row(0, 8'h44, 3, 1'b0, 1'b0);
        check_done(2'b01);
        tick;
        check_idle_after_done();
        tick;
        check("cont2_gnt", 32'(bus.oGNT), 2);
        check("cont2_row_idx", 32'(bus.oROW_IDX), 0);
        do_row(1, 8'h55, 0, 1'b0, 1'b0);
        do_row(1, 8'h66, 1, 1'b0, 1'b0);
        do_row(1, 8'h77, 2, 1'b0, 1'b0);
        do_row(1, 8'h88, 3, 1'b0, 1'b0);
        check_done(2'b10);
        bus.iREQ = 2'b00;
        tick;
        check_idle_after_done();

        // Abort: source 1 alone, drops request during row 2 WAIT.
        bus.iREQ = 2'b10;
        tick;
        check("abort_gnt", 32'(bus.oGNT), 2);
        do_row(1, 8'hC1, 0, 1'b0, 1'b0);
        do_row(1, 8'hC2, 1, 1'b0, 1'b0);
        do_row(1, 8'hC3, 2, 1'b0, 1'b1);
        check("abort_fetch_idx", 32'(bus.oROW_IDX), 3);
        tick;
        check("abort_busy", 32'(bus.oBUSY), 0);
        check("abort_gnt_clr", 32'(bus.oGNT), 0);
        check("abort_row_rd", 32'(bus.oROW_RD), 0);
        check("abort_no_done", 32'(bus.oFRAME_DONE), 0);
        check("abort_no_start", 32'(bus.oSER_START), 0);
        tick;
        check("abort_no_done_later", 32'(bus.oFRAME_DONE), 0);

        // Single frame from source 0 while the pointer favours source 1.
        bus.iREQ = 2'b01;
        tick;
        check("single_gnt", 32'(bus.oGNT), 1);
        do_row(0, 8'hA5, 0, 1'b0, 1'b0);
        do_row(0, 8'h3C, 1, 1'b0, 1'b0);
        do_row(0, 8'hFF, 2, 1'b0, 1'b0);
        do_row(0, 8'h01, 3, 1'b0, 1'b0);
        check_done(2'b01);
        bus.iREQ = 2'b00;
        tick;
        check_idle_after_done();

        // Stray handshakes: finished in IDLE, then in START, wrong-source valid.
        bus.iSER_FINISHED = 1'b1;
        tick;
        bus.iSER_FINISHED = 1'b0;
        check("stray_idle_busy", 32'(bus.oBUSY), 0);
        check("stray_idle_row_rd", 32'(bus.oROW_RD), 0);
        bus.iREQ = 2'b01;
        tick;
        check("stray_gnt", 32'(bus.oGNT), 1);
        do_row(0, 8'hAA, 0, 1'b1, 1'b0);
        do_row(0, 8'hBB, 1, 1'b1, 1'b0);
        do_row(0, 8'hCC, 2, 1'b0, 1'b0);
        do_row(0, 8'hDD, 3, 1'b0, 1'b0);
        check_done(2'b01);
        bus.iREQ = 2'b00;
        tick;
        check_idle_after_done();

        // Reset mid-frame during row 1 WAIT; pointer favours source 1 before it.
        bus.iREQ = 2'b01;
        tick;
        do_row(0, 8'h12, 0, 1'b0, 1'b0);
        fetch_and_start(0, 8'h34, 1'b0);
        tick;
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("midreset");
        bus.iREQ = 2'b00;
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        tick;
        bus.iREQ = 2'b11;
        tick;
        check("postreset_gnt", 32'(bus.oGNT), 1);

        // Watchdog: the shifter never finishes this row.
        fetch_and_start(0, 8'h99, 1'b0);
        tick;
`ifdef FRAME_ROW_SCHED_WATCHDOG_EN
        for (int i = 1; i <= 40; i++) begin
            tick;
            if (bus.oERR === 1'b1) begin
                err_cyc = i;
                break;
            end
        end
        check("wd_err_cycle", 32'(err_cyc), 24);
        check("wd_busy_at_err", 32'(bus.oBUSY), 0);
        check("wd_gnt_at_err", 32'(bus.oGNT), 0);
        check("wd_no_done", 32'(bus.oFRAME_DONE), 0);
        tick;
        check("wd_err_one_cycle", 32'(bus.oERR), 0);
        check("wd_idle", 32'(bus.oBUSY), 0);
`else
        for (int i = 1; i <= 40; i++) begin
            tick;
            if (bus.oERR !== 1'b0) err_cnt++;
        end
        check("nowd_err_count", 32'(err_cnt), 0);
        check("nowd_busy", 32'(bus.oBUSY), 1);
        check("nowd_gnt", 32'(bus.oGNT), 1);
`endif
        bus.iREQ = 2'b00;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/frame_row_scheduler.md
# frame_row_scheduler

Sequences the row-wide parallel-to-serial shifter for whole frames, one row at a time. Arbitrates frame ownership between two row sources: source 0 is the live capture path and source 1 is the stored flash image. For each row, the block fetches the row from the granted source, latches it, pulses the shifter start, and waits for the shifter's finished pulse. It raises a frame-done pulse after the last row.

## Interface
- ROW_BITS, 640, width of one row (pixels per row, 1 bit per pixel); ≥1
- ROWS, 480, rows per frame; ≥1
- RIDX_W, $clog2(ROWS) (min 1), width of row index
- iCLK  in  1  clock; all logic on rising edge
- iRST_n  in  1  reset; one clock, asynchronous active-low reset
- iREQ  in  2  frame request per source; must be held until oFRAME_DONE
- oGNT  out  2  one-hot grant, held for the whole frame
- oROW_RD  out  1  row fetch request to the granted source (level)
- iROW_VALID  in  2  per-source row-data-valid
- iROW_DATA0  in  ROW_BITS  row data, source 0
- iROW_DATA1  in  ROW_BITS  row data, source 1
- oSER_DATA  out  ROW_BITS  latched row presented to the shifter
- oSER_START  out  1  one-cycle shifter start pulse
- iSER_FINISHED  in  1  shifter row-complete pulse
- oROW_IDX  out  RIDX_W  index of the row currently in flight
- oFRAME_DONE  out  1  one-cycle pulse after the last row completes
- oBUSY  out  1  high in every state except IDLE
- oERR  out  1  one-cycle watchdog abort pulse (see Configuration)

## Operation
- States: IDLE, FETCH, START, WAIT, DONE. All outputs are registered.
- **Reset:**
  - State goes to IDLE.
  - oGNT, oROW_RD, oSER_START, oFRAME_DONE, oBUSY and oERR are 0.
  - oSER_DATA and oROW_IDX are 0.
  - Round-robin pointer is 0, so source 0 is favoured.
- **IDLE:**
  - If any iREQ bit is set, grant one source and go to FETCH with oROW_IDX=0.
  - If both are set, the pointer picks the winner.
  - If exactly one is set, it wins regardless of the pointer.
- **FETCH:**
  - oROW_RD=1.
  - When iROW_VALID[g]=1 for granted source g, latch iROW_DATA<g> into oSER_DATA and go to START.
  - Valid from the non-granted source is ignored.
  - If iREQ[g]=0 while in FETCH, abort: go to IDLE, clear oGNT, toggle the pointer, and do not pulse oFRAME_DONE.
- **START:** oSER_START=1 for exactly one cycle, then go to WAIT. iSER_FINISHED is ignored in START.
- **WAIT:**
  - On iSER_FINISHED: if oROW_IDX==ROWS-1, go to DONE.
  - Otherwise increment oROW_IDX and go to FETCH.
  - A dropped iREQ is not checked in WAIT. The current row always completes, and the abort takes effect at the next FETCH.
- **DONE:**
  - oFRAME_DONE=1 for one cycle.
  - oGNT clears on leaving DONE.
  - Pointer is set to favour the other source.
  - Return to IDLE. iREQ is not evaluated in DONE.
- iSER_FINISHED outside WAIT is ignored.
- oROW_IDX never exceeds ROWS-1 and does not wrap within a frame.
- oSER_DATA holds its value from the latch until the next latch.

## Timing
- Grant latency: iREQ sampled high at edge k in IDLE → oGNT and oROW_RD are high after edge k.
- Row accept at edge m (oROW_RD & iROW_VALID[g]) → oSER_DATA valid and oSER_START=1 in cycle m+1. oROW_RD drops after edge m.
- iSER_FINISHED at edge n:
  - Not the last row: oROW_RD=1 from cycle n+1.
  - Last row: oFRAME_DONE=1 in cycle n+1, and IDLE (oBUSY=0) in cycle n+2.
- Minimum row period: 3 cycles (FETCH, START, WAIT of 1 cycle).
- Back-to-back frames: the earliest next grant is 1 cycle after the IDLE cycle.
- Reset asserted mid-frame: all outputs go to their reset values immediately. The shifter is not notified.

## Configuration
- **FRAME_ROW_SCHED_WATCHDOG_EN defined:**
  - A counter runs in WAIT.
  - If iSER_FINISHED is not seen within ROW_BITS+16 cycles of entering WAIT, pulse oERR for one cycle, go to IDLE, clear oGNT and toggle the pointer.
  - oFRAME_DONE is not pulsed.
- **Not defined:** no counter; oERR is tied to 0; WAIT waits indefinitely.

## Test plan
All scenarios use ROW_BITS=8, ROWS=4, and a shifter model that returns finished 9 cycles after start.
- **Single frame:** iREQ=01, source 0 returns rows 8'hA5, 8'h3C, 8'hFF, 8'h01 with valid 1 cycle after oROW_RD → oSER_DATA takes those values in order, with 4 oSER_START pulses, oROW_IDX 0..3, and exactly one oFRAME_DONE; oGNT=01 throughout.
- **Contention fairness:** iREQ=11 held across two frames → first frame oGNT=01, second frame oGNT=10; rows of source 1 appear on oSER_DATA only in the second frame.
- **Abort:** source 1 drops iREQ during row 2 WAIT → row 2 completes, then IDLE at the next FETCH; no oFRAME_DONE; oBUSY=0.
- **Stray handshakes:** iSER_FINISHED pulsed in IDLE and START, and iROW_VALID=10 while oGNT=01 → no state change and no latch; the frame still completes with 4 rows.
- **Reset mid-frame:** iRST_n low during row 1 WAIT → all outputs 0 asynchronously. After release, iREQ=11 grants source 0.
- **Watchdog (macro defined):** shifter never finishes → oERR pulses exactly 24 cycles after WAIT entry, then IDLE. Without the macro, oERR stays 0 and oBUSY stays 1.
